// File: rtl/game_flow_pkg.sv
// Shared game-flow types and USB keycodes.
// Latency: n/a. Backpressure: n/a.
package game_flow_pkg;

    typedef enum logic [2:0] {
        MENU      = 3'd0,
        INTRO     = 3'd1,
        PLAY      = 3'd2,
        PAUSE     = 3'd3,
        WIN       = 3'd4,
        GAME_OVER = 3'd5
    } game_state_t;

    localparam logic [7:0] KEY_START = 8'h28;
    localparam logic [7:0] KEY_PAUSE = 8'h13;

    // Zero is the "no key" code and must never produce a match.
    function automatic logic key_match(input logic [15:0] codes, input logic [7:0] key);
        return (key != 8'h00) && ((codes[7:0] == key) || (codes[15:8] == key));
    endfunction

endpackage

// File: rtl/boss_attack_scheduler.sv
// Boss special-attack window timer with elec_frame animation phase.
// Latency: outputs registered, update on the Clk after a qualifying tick.
// Backpressure: none; hold freezes all state, idle (neither run nor hold) clears it.
module boss_attack_scheduler #(
    parameter int ATTACK_PERIOD = 600,
    parameter int ATTACK_LEN    = 120,
    parameter int ELEC_DIV      = 8
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic tick,
    input  logic run,
    input  logic hold,
    output logic boss_special_attack,
    output logic elec_frame
);

    localparam int AW = $clog2(ATTACK_PERIOD + 1);
    localparam int LW = $clog2(ATTACK_LEN + 1);
    localparam int DW = $clog2(ELEC_DIV + 1);

    localparam logic [AW-1:0] A_LAST = AW'(ATTACK_PERIOD - 1);
    localparam logic [LW-1:0] L_LAST = LW'(ATTACK_LEN - 1);
    localparam logic [DW-1:0] D_LAST = DW'(ELEC_DIV - 1);

    logic [AW-1:0] acnt;
    logic [LW-1:0] lcnt;
    logic [DW-1:0] dcnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            acnt                <= '0;
            lcnt                <= '0;
            dcnt                <= '0;
            boss_special_attack <= 1'b0;
            elec_frame          <= 1'b0;
        end else if (!run && !hold) begin
            acnt                <= '0;
            lcnt                <= '0;
            dcnt                <= '0;
            boss_special_attack <= 1'b0;
            elec_frame          <= 1'b0;
        end else if (run && tick) begin
            // The period counter keeps running through a window so starts stay evenly spaced.
            acnt <= (acnt == A_LAST) ? '0 : acnt + AW'(1);
            if (boss_special_attack) begin
                if (lcnt == L_LAST) begin
                    boss_special_attack <= 1'b0;
                    elec_frame          <= 1'b0;
                    lcnt                <= '0;
                    dcnt                <= '0;
                end else begin
                    lcnt <= lcnt + LW'(1);
                    if (dcnt == D_LAST) begin
                        dcnt       <= '0;
                        elec_frame <= ~elec_frame;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
            end else if (acnt == A_LAST) begin
                boss_special_attack <= 1'b1;
                elec_frame          <= 1'b0;
                lcnt                <= '0;
                dcnt                <= '0;
            end
        end
    end

endmodule

// File: rtl/game_flow_controller.sv
// Game sequencer: vsync frame tick, key edge detect, MENU..GAME_OVER FSM, boss attack scheduling.
// Latency: frame_tick 3 Clk after vs rise; state/flags registered, 1 Clk after the deciding input.
// Backpressure: none; held keys give a single event, PAUSE freezes frame and attack counters.
module game_flow_controller
    import game_flow_pkg::*;
#(
    parameter int INTRO_FRAMES  = 180,
    parameter int OVER_FRAMES   = 300,
    parameter int ATTACK_PERIOD = 600,
    parameter int ATTACK_LEN    = 120,
    parameter int ELEC_DIV      = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        vs,
    input  logic [15:0] keycode,
    input  logic [3:0]  player_lives,
    input  logic [9:0]  boss_health,
    output game_state_t state,
    output logic        menu,
    output logic        intro,
    output logic        playing,
    output logic        paused,
    output logic        win,
    output logic        game_over,
    output logic        game_reset,
    output logic        frame_tick,
    output logic        boss_special_attack,
    output logic        elec_frame
);

    localparam int FMAX = (INTRO_FRAMES > OVER_FRAMES) ? INTRO_FRAMES : OVER_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);

    localparam logic [FW-1:0] INTRO_LAST = FW'(INTRO_FRAMES - 1);
    localparam logic [FW-1:0] OVER_LAST  = FW'(OVER_FRAMES - 1);

    logic          vs_s1, vs_s2, vs_d;
    logic          start_prev, pause_prev;
    logic          start_now, pause_now, start_hit, pause_hit;
    logic [FW-1:0] fcnt;
    game_state_t   nxt;

    assign start_now = key_match(keycode, KEY_START);
    assign pause_now = key_match(keycode, KEY_PAUSE);
    assign start_hit = start_now && !start_prev;
    assign pause_hit = pause_now && !pause_prev;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_s1      <= 1'b0;
            vs_s2      <= 1'b0;
            vs_d       <= 1'b0;
            frame_tick <= 1'b0;
            start_prev <= 1'b0;
            pause_prev <= 1'b0;
        end else begin
            vs_s1      <= vs;
            vs_s2      <= vs_s1;
            vs_d       <= vs_s2;
            frame_tick <= vs_s2 && !vs_d;
            start_prev <= start_now;
            pause_prev <= pause_now;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            MENU:      if (start_hit) nxt = INTRO;
            INTRO:     if (start_hit || (frame_tick && fcnt == INTRO_LAST)) nxt = PLAY;
            PLAY: begin
                if (player_lives == 4'd0)      nxt = GAME_OVER;
                else if (boss_health == 10'd0) nxt = WIN;
                else if (pause_hit)            nxt = PAUSE;
            end
            PAUSE:     if (pause_hit) nxt = PLAY;
            WIN, GAME_OVER:
                       if (start_hit || (frame_tick && fcnt == OVER_LAST)) nxt = MENU;
            default:   nxt = MENU;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= MENU;
            menu       <= 1'b1;
            intro      <= 1'b0;
            playing    <= 1'b0;
            paused     <= 1'b0;
            win        <= 1'b0;
            game_over  <= 1'b0;
            game_reset <= 1'b0;
            fcnt       <= '0;
        end else begin
            state      <= nxt;
            menu       <= (nxt == MENU);
            intro      <= (nxt == INTRO);
            playing    <= (nxt == PLAY);
            paused     <= (nxt == PAUSE);
            win        <= (nxt == WIN);
            game_over  <= (nxt == GAME_OVER);
            game_reset <= (state == MENU) && (nxt == INTRO);
            // Only timed states count; the terminal value always forces a state change, so no wrap is needed.
            if (nxt != state)
                fcnt <= '0;
            else if (frame_tick && (state == INTRO || state == WIN || state == GAME_OVER))
                fcnt <= fcnt + FW'(1);
        end
    end

    boss_attack_scheduler #(
        .ATTACK_PERIOD (ATTACK_PERIOD),
        .ATTACK_LEN    (ATTACK_LEN),
        .ELEC_DIV      (ELEC_DIV)
    ) u_sched (
        .Clk                 (Clk),
        .Reset_n             (Reset_n),
        .tick                (frame_tick),
        .run                 (state == PLAY),
        .hold                (state == PAUSE),
        .boss_special_attack (boss_special_attack),
        .elec_frame          (elec_frame)
    );

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with hand-computed expectations.
module tb_game_flow_controller;
    import game_flow_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        vs;
    logic [15:0] keycode;
    logic [3:0]  player_lives;
    logic [9:0]  boss_health;
    game_state_t state;
    logic        menu, intro, playing, paused, win, game_over;
    logic        game_reset, frame_tick, boss_special_attack, elec_frame;

    int checks = 0;
    int errors = 0;
    int gr_cnt;

    game_flow_controller dut (
        .Clk                 (Clk),
        .Reset_n             (Reset_n),
        .vs                  (vs),
        .keycode             (keycode),
        .player_lives        (player_lives),
        .boss_health         (boss_health),
        .state               (state),
        .menu                (menu),
        .intro               (intro),
        .playing             (playing),
        .paused              (paused),
        .win                 (win),
        .game_over           (game_over),
        .game_reset          (game_reset),
        .frame_tick          (frame_tick),
        .boss_special_attack (boss_special_attack),
        .elec_frame          (elec_frame)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame: vs high 2 Clk, low 2 Clk; its tick has been consumed by the FSM on return.
    task automatic vs_pulse();
        @(negedge Clk) vs = 1'b1;
        repeat (2) @(negedge Clk);
        vs = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) vs_pulse();
    endtask

    task automatic press(input logic [15:0] code);
        @(negedge Clk) keycode = code;
        @(negedge Clk) keycode = 16'h0000;
    endtask

    initial begin
        Reset_n      = 1'b0;
        vs           = 1'b0;
        keycode      = 16'h0000;
        player_lives = 4'd3;
        boss_health  = 10'd100;
        #12;
        chk("reset_state", state, MENU);
        chk("reset_menu", menu, 1'b1);
        chk("reset_flags", {intro, playing, paused, win, game_over, game_reset}, 6'b0);
        chk("reset_misc", {frame_tick, boss_special_attack, elec_frame}, 3'b0);
        @(negedge Clk) Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // vs rise -> frame_tick exactly 3 Clk later, one Clk wide
        for (int p = 0; p < 3; p++) begin
            @(negedge Clk) vs = 1'b1;
            @(posedge Clk); #1 chk("tick_lat1", frame_tick, 1'b0);
            @(posedge Clk); #1 chk("tick_lat2", frame_tick, 1'b0);
            vs = 1'b0;
            @(posedge Clk); #1 chk("tick_lat3", frame_tick, 1'b1);
            @(posedge Clk); #1 chk("tick_width", frame_tick, 1'b0);
            repeat (2) @(negedge Clk);
        end
        chk("menu_after_vs", state, MENU);
        chk("menu_flag_vs", menu, 1'b1);

        // Held start key: one game_reset pulse, alongside entry to INTRO
        gr_cnt = 0;
        @(negedge Clk) keycode = 16'h0028;
        for (int i = 0; i < 100; i++) begin
            @(posedge Clk); #1;
            if (game_reset) gr_cnt++;
            if (i == 0) begin
                chk("start_game_reset", game_reset, 1'b1);
                chk("start_to_intro", state, INTRO);
                chk("intro_flag", {menu, intro}, 2'b01);
            end
        end
        chk("game_reset_count", gr_cnt[15:0], 16'd1);
        chk("intro_held", state, INTRO);
        @(negedge Clk) keycode = 16'h0000;

        frames(179);
        chk("intro_179", state, INTRO);
        frames(1);
        chk("intro_180", state, PLAY);
        chk("playing_flag", {intro, playing}, 2'b01);

        // Attack window opens on the 600th PLAY tick
        frames(599);
        chk("attack_599", boss_special_attack, 1'b0);
        frames(1);
        chk("attack_600", boss_special_attack, 1'b1);
        chk("elec_start", elec_frame, 1'b0);
        frames(7);
        chk("elec_7", elec_frame, 1'b0);
        frames(1);
        chk("elec_8", elec_frame, 1'b1);
        frames(32);
        chk("elec_40", elec_frame, 1'b1);

        press(16'h0013);
        chk("pause_enter", state, PAUSE);
        chk("paused_flag", {playing, paused}, 2'b01);
        player_lives = 4'd0;
        frames(50);
        chk("pause_frozen_state", state, PAUSE);
        chk("pause_frozen_attack", {boss_special_attack, elec_frame}, 2'b11);
        player_lives = 4'd3;
        press(16'h0013);
        chk("pause_exit", state, PLAY);

        // 80 attack ticks remained when paused
        frames(79);
        chk("attack_119", boss_special_attack, 1'b1);
        chk("elec_119", elec_frame, 1'b0);
        frames(1);
        chk("attack_end", {boss_special_attack, elec_frame}, 2'b00);

        // Death beats win
        @(negedge Clk);
        player_lives = 4'd0;
        boss_health  = 10'd0;
        @(negedge Clk);
        chk("death_over_win", state, GAME_OVER);
        chk("game_over_flag", {win, game_over}, 2'b01);
        frames(299);
        chk("over_299", state, GAME_OVER);
        frames(1);
        chk("over_300", state, MENU);

        // Reach WIN via start-skip of INTRO, then leave with start in the upper byte
        player_lives = 4'd3;
        boss_health  = 10'd50;
        press(16'h0028);
        chk("menu_to_intro2", state, INTRO);
        press(16'h0028);
        chk("intro_skip", state, PLAY);
        @(negedge Clk) boss_health = 10'd0;
        @(negedge Clk);
        chk("win_state", state, WIN);
        chk("win_flag", {win, game_over}, 2'b10);
        @(negedge Clk) keycode = 16'h2800;
        @(posedge Clk); #1;
        chk("win_upper_key", state, MENU);
        chk("win_no_reset_pulse", game_reset, 1'b0);
        @(negedge Clk) keycode = 16'h0000;

        // Async reset in the middle of an attack
        boss_health = 10'd100;
        press(16'h0028);
        press(16'h0028);
        chk("play_again", state, PLAY);
        frames(605);
        chk("attack_again", boss_special_attack, 1'b1);
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_state", state, MENU);
        chk("arst_menu", menu, 1'b1);
        chk("arst_outs", {playing, game_reset, frame_tick, boss_special_attack, elec_frame}, 5'b0);
        @(negedge Clk) Reset_n = 1'b1;
        @(negedge Clk);
        chk("post_arst", {state, game_reset}, {MENU, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
